alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU operand/op interface. Takes a fetched RV32I instruction plus register-file reads.
//  Decodes R-type (0110011) and OP-IMM (0010011) instructions into {a, b, alu_op, rd}.
//  Buffers the result in a 2-entry skid buffer toward the execute stage.
//  Valid/ready on both sides; full throughput with a registered in_ready.
// PARAMETERS
//  XLEN      32  datapath width of operands and pc
//  OP_W       4  width of alu_op
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     synchronous reset, active-low
//  in_valid     in   1     upstream offers instruction
//  in_ready     out  1     stage can accept (registered)
//  in_instr     in   32    instruction word
//  in_rs1_val   in   XLEN  rs1 value
//  in_rs2_val   in   XLEN  rs2 value
//  in_pc        in   XLEN  pc of instruction
//  flush        in   1     discard all buffered entries
//  out_valid    out  1     entry available to execute
//  out_ready    in   1     execute accepts entry
//  out_a        out  XLEN  ALU operand a
//  out_b        out  XLEN  ALU operand b
//  out_alu_op   out  OP_W  ALU op code
//  out_rd       out  5     destination register
//  out_rd_we    out  1     write-back enable (0 when rd==0 or illegal)
//  out_illegal  out  1     instruction not decodable by this stage
// BEHAVIOUR
//  - Reset (rst_n low at posedge):
//    - state=EMPTY; in_ready=1; out_valid=0.
//    - out_a/out_b/out_alu_op/out_rd/out_rd_we/out_illegal = 0.
//  - alu_op encoding:
//    - add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
//  - R-type decode:
//    - alu_op = {funct7[5], funct3}; a = rs1_val; b = rs2_val.
//    - funct7 must be 0000000, or 0100000 with funct3 000/101; otherwise illegal.
//  - OP-IMM decode:
//    - a = rs1_val; b = sign-extended imm[11:0].
//    - alu_op = {funct3==101 ? funct7[5] : 0, funct3}.
//    - For slli/srli/srai, b = zero-extended shamt (instr[24:20]).
//    - funct7 is checked as for R-type, with only 000 allowed for slli.
//  - Illegal entries: any other opcode or bad funct7.
//    - out_illegal=1, out_rd_we=0, alu_op=0000, a=b=0.
//    - They still pass through in order.
//  - Transfer rules:
//    - Input transfer occurs when in_valid & in_ready.
//    - Output transfer occurs when out_valid & out_ready.
//    - Decode is combinational into the buffer; latency is 1 cycle from input transfer to out_valid when EMPTY.
//  - Skid FSM (entries held, output always from head):
//    - EMPTY: in xfer -> ONE.
//    - ONE: in xfer & out xfer -> ONE (head replaced). in only -> TWO. out only -> EMPTY.
//    - TWO: out xfer -> ONE (tail becomes head). in_ready=0 in TWO.
//    - in_ready = (next_state != TWO), registered.
//  - flush:
//    - Wins over every simultaneous transfer.
//    - Next state EMPTY, out_valid=0, in_ready=1.
//    - Any concurrent input transfer is dropped.
//  - Output data is held stable while out_valid & !out_ready.
//  - rst_n low mid-operation discards all entries exactly like reset.
// CONFIGURATION
//  - ALU_ISSUE_UPPER_EN defined: additionally decodes LUI (0110111) and AUIPC (0010111).
//    - LUI: a=0, b={imm[31:12],12'b0}, op=add.
//    - AUIPC: a=in_pc, same b, op=add.
//  - Undefined: both opcodes are illegal; in_pc is unused.
// TESTING
//  - add x3,x1,x2 (0x002081B3), rs1=5, rs2=7:
//    -> next cycle out_valid=1, a=5, b=7, op=0000, rd=3, rd_we=1.
//  - sub 0x402081B3, rs1=0, rs2=1:
//    -> op=1000, a=0, b=1.
//  - srai x5,x6,4 (0x40435293) -> op=1101, b=4, rd=5.
//  - addi x1,x0,-1 (0xFFF00093) -> op=0000, b=0xFFFFFFFF.
//  - addi x0,x0,0 -> rd_we=0.
//  - out_ready=0 with 3 back-to-back valid inputs:
//    -> in_ready drops after 2 accepted; head stable.
//    -> Raise out_ready: entries emerge in order, no loss or duplication.
//  - flush asserted in state TWO with in_valid=1:
//    -> next cycle out_valid=0, in_ready=1, nothing emitted.
//  - Opcode 0x0000007F -> out_illegal=1, rd_we=0.
//  - With ALU_ISSUE_UPPER_EN, LUI x7,0x12345 (0x123453B7):
//    -> a=0, b=0x12345000, op=0000.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: operand/op handshake bundle around the ALU issue stage.
//   Upstream side : in_valid/in_ready plus instruction, rs1/rs2 values and pc.
//   Control       : flush discards everything buffered in the stage.
//   Execute side  : out_valid/out_ready plus a, b, alu_op, rd, rd_we, illegal.
// Modports:
//   master - the issue stage (drives in_ready and all out_* except out_ready)
//   slave  - the environment (fetch/regfile upstream and execute downstream)
interface alu_issue_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [OP_W-1:0] out_alu_op;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_illegal;

  modport master (
    input  in_valid, in_instr, in_rs1_val, in_rs2_val, in_pc, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_rd_we, out_illegal
  );

  modport slave (
    output in_valid, in_instr, in_rs1_val, in_rs2_val, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_rd_we, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I R-type and OP-IMM instructions into ALU
// operands {a, b, alu_op, rd} and holds them in a 2-entry skid buffer toward
// the execute stage. in_ready is registered; throughput is one per cycle.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset; clears state and output data
//   io     - alu_issue_if.master (upstream handshake, flush, execute handshake)
// Build option:
//   ALU_ISSUE_UPPER_EN - when defined, LUI and AUIPC are decoded as adds;
//                        otherwise both are illegal and in_pc is unused.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.master  io
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OP_W-1:0] op;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       is_shift;
  entry_t     dec_p0;

  assign opcode   = io.in_instr[6:0];
  assign funct3   = io.in_instr[14:12];
  assign funct7   = io.in_instr[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Stage p0: combinational decode of the offered instruction
  always_comb begin
    dec_p0    = '0;
    legal     = 1'b0;
    dec_p0.rd = io.in_instr[11:7];
    case (opcode)
      7'b0110011: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        if (legal) begin
          dec_p0.a  = io.in_rs1_val;
          dec_p0.b  = io.in_rs2_val;
          dec_p0.op = OP_W'({funct7[5], funct3});
        end
      end
      7'b0010011: begin
        // funct7 only exists for shifts; elsewhere those bits are immediate
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
        if (legal) begin
          dec_p0.a  = io.in_rs1_val;
          dec_p0.b  = is_shift ? XLEN'(io.in_instr[24:20])
                               : XLEN'($signed(io.in_instr[31:20]));
          dec_p0.op = OP_W'({(funct3 == 3'b101) & funct7[5], funct3});
        end
      end
`ifdef ALU_ISSUE_UPPER_EN
      7'b0110111: begin
        legal    = 1'b1;
        dec_p0.b = XLEN'($signed({io.in_instr[31:12], 12'b0}));
      end
      7'b0010111: begin
        legal    = 1'b1;
        dec_p0.a = io.in_pc;
        dec_p0.b = XLEN'($signed({io.in_instr[31:12], 12'b0}));
      end
`else
`endif
      default: legal = 1'b0;
    endcase
    dec_p0.illegal = !legal;
    dec_p0.rd_we   = legal && (io.in_instr[11:7] != 5'd0);
  end

  logic [1:0] state;
  logic [1:0] next_state;
  logic       in_ready_r;
  logic       in_xfer;
  logic       out_xfer;
  logic       head_load;
  logic       head_from_tail;
  logic       tail_load;
  entry_t     head_p1;
  entry_t     tail_p1;

  assign in_xfer  = io.in_valid && in_ready_r;
  assign out_xfer = (state != EMPTY) && io.out_ready;

  always_comb begin
    next_state     = state;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        next_state = ONE;
        head_load  = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_load = 1'b1;
        end else if (in_xfer) begin
          next_state = TWO;
          tail_load  = 1'b1;
        end else if (out_xfer) begin
          next_state = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        next_state     = ONE;
        head_from_tail = 1'b1;
      end
      default: next_state = EMPTY;
    endcase
    // flush overrides every transfer, including an accepted input
    if (io.flush) begin
      next_state     = EMPTY;
      head_load      = 1'b0;
      head_from_tail = 1'b0;
      tail_load      = 1'b0;
    end
  end

  // Stage p1: skid buffer registers; the head entry drives the outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_r <= 1'b1;
      head_p1    <= '0;
    end else begin
      state      <= next_state;
      in_ready_r <= (next_state != TWO);
      if (head_load)           head_p1 <= dec_p0;
      else if (head_from_tail) head_p1 <= tail_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (tail_load) tail_p1 <= dec_p0;
  end

  assign io.in_ready    = in_ready_r;
  assign io.out_valid   = (state != EMPTY);
  assign io.out_a       = head_p1.a;
  assign io.out_b       = head_p1.b;
  assign io.out_alu_op  = head_p1.op;
  assign io.out_rd      = head_p1.rd;
  assign io.out_rd_we   = head_p1.rd_we;
  assign io.out_illegal = head_p1.illegal;

endmodule
